// File: rtl/dl_recv_if.sv
// Stream bus of the downlink TDM de-interleaver: the slotted TDM input and the
// paired freq0/freq1 lane output.
`timescale 1ns/1ps
interface dl_recv_if;
    logic [31:0] i_freq_tdata;
    logic        i_freq_tfram;
    logic        i_freq_txant;
    logic [31:0] o_freq0_fdata;
    logic [31:0] o_freq1_fdata;
    logic        o_freq_fvalid;
    logic        o_freq_ffram;

    modport master (
        output i_freq_tdata, i_freq_tfram, i_freq_txant,
        input  o_freq0_fdata, o_freq1_fdata, o_freq_fvalid, o_freq_ffram
    );

    modport slave (
        input  i_freq_tdata, i_freq_tfram, i_freq_txant,
        output o_freq0_fdata, o_freq1_fdata, o_freq_fvalid, o_freq_ffram
    );
endinterface

// File: rtl/dl_recv.sv
// Downlink TDM de-interleaver: splits the antenna-slotted stream into freq0/freq1
// lane pairs, recovers frame timing from tfram and checks the txant cadence.
`timescale 1ns/1ps
module dl_recv #(
    parameter int ERR_LOST_N = 4
) (
    input  logic        clk_491,
    input  logic        rst_491,
    input  logic [31:0] i_bandwidth_sel,
    dl_recv_if.slave    freq,
    output logic        o_sync_err,
    output logic [15:0] o_err_cnt,
    output logic        o_locked
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_LOST = 2'd2} state_t;

    localparam int CW = $clog2(ERR_LOST_N + 1);
    localparam logic [CW-1:0] CONS_LAST = CW'(ERR_LOST_N - 1);

    // Period is kept as a mask (P-1) so the cadence test is a plain AND.
    function automatic logic [4:0] period_mask(input logic [3:0] code);
        logic [4:0] m;
        case (code)
            4'd1:       m = 5'd31;
            4'd2, 4'd3: m = 5'd15;
            default:    m = 5'd7;
        endcase
        return m;
    endfunction

    logic [31:0]   data_r;
    logic          fram_r;
    logic          xant_r;
    logic [4:0]    slot_r;
    logic [3:0]    sel_r;
    logic [4:0]    mask_r;
    logic          first_grp_r;
    logic [31:0]   dly_r [4];
    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cons_r;
    logic [15:0]   err_cnt_r;
    logic          expect_xant_s;
    logic          mismatch_s;
    logic          pair_valid_s;
    logic          ffram_s;
    logic [31:0]   f0_r;
    logic [31:0]   f1_r;
    logic          fvalid_r;
    logic          ffram_r;
    logic          sync_err_r;
    logic          locked_r;
    logic          unused_sel_s;

    assign unused_sel_s = ^i_bandwidth_sel[31:4];

    // Input stage: single register copy that all slot logic works on
    always_ff @(posedge clk_491) begin
        if (rst_491) begin
            data_r <= 32'd0;
            fram_r <= 1'b0;
            xant_r <= 1'b0;
        end else begin
            data_r <= freq.i_freq_tdata;
            fram_r <= freq.i_freq_tfram;
            xant_r <= freq.i_freq_txant;
        end
    end

    // Slot timing, bandwidth period and the freq0 delay line
    always_ff @(posedge clk_491) begin
        if (rst_491) begin
            slot_r      <= 5'd0;
            sel_r       <= 4'd0;
            mask_r      <= 5'd7;
            first_grp_r <= 1'b0;
            for (int i = 0; i < 4; i++) dly_r[i] <= 32'd0;
        end else begin
            if (freq.i_freq_tfram) sel_r <= i_bandwidth_sel[3:0];
            if (fram_r) begin
                slot_r      <= 5'd0;
                mask_r      <= period_mask(sel_r);
                first_grp_r <= 1'b1;
            end else begin
                slot_r <= slot_r + 5'd1;
                if (slot_r == 5'd7) first_grp_r <= 1'b0;
            end
            // Shifting every slot keeps the freq0 word of 4 slots ago on the oldest tap
            dly_r[0] <= data_r;
            for (int i = 1; i < 4; i++) dly_r[i] <= dly_r[i-1];
        end
    end

    // State register and mismatch counters
    always_ff @(posedge clk_491) begin
        if (rst_491) begin
            state_r   <= ST_IDLE;
            cons_r    <= '0;
            err_cnt_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_LOST) && fram_r) begin
                cons_r <= '0;
            end else if (mismatch_s) begin
                cons_r <= cons_r + 1'b1;
            end else if ((state_r == ST_RUN) && xant_r) begin
                cons_r <= '0;
            end
            if (mismatch_s && (err_cnt_r != 16'hFFFF)) err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fram_r) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (mismatch_s && (cons_r == CONS_LAST)) state_nxt_s = ST_LOST;
                else                                     state_nxt_s = ST_RUN;
            end
            ST_LOST: begin
                if (fram_r) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_LOST;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: lane pairing and cadence check, active only in RUN
    always_comb begin
        expect_xant_s = ((slot_r & mask_r) == mask_r);
        if (state_r == ST_RUN) begin
            mismatch_s   = (xant_r != expect_xant_s);
            pair_valid_s = slot_r[2];
            ffram_s      = slot_r[2] && first_grp_r && (slot_r[1:0] == 2'd0);
        end else begin
            mismatch_s   = 1'b0;
            pair_valid_s = 1'b0;
            ffram_s      = 1'b0;
        end
    end

    // Output registers; lane data holds its last value between pairs
    always_ff @(posedge clk_491) begin
        if (rst_491) begin
            f0_r       <= 32'd0;
            f1_r       <= 32'd0;
            fvalid_r   <= 1'b0;
            ffram_r    <= 1'b0;
            sync_err_r <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            if (pair_valid_s) begin
                f0_r <= dly_r[3];
                f1_r <= data_r;
            end
            fvalid_r   <= pair_valid_s;
            ffram_r    <= ffram_s;
            sync_err_r <= mismatch_s;
            locked_r   <= (state_nxt_s == ST_RUN);
        end
    end

    assign freq.o_freq0_fdata = f0_r;
    assign freq.o_freq1_fdata = f1_r;
    assign freq.o_freq_fvalid = fvalid_r;
    assign freq.o_freq_ffram  = ffram_r;
    assign o_sync_err         = sync_err_r;
    assign o_err_cnt          = err_cnt_r;
    assign o_locked           = locked_r;
endmodule

// File: tb/tb_dl_recv.sv
// Randomized bench for dl_recv against a cycle-indexed model built from the
// framing, pairing and cadence rules of the de-interleaver.
`timescale 1ns/1ps
module tb_dl_recv;
    localparam int LOSTN  = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LOST = 2;

    logic        clk_491 = 1'b0;
    logic        rst_491 = 1'b1;
    logic [31:0] bw_sel  = 32'd0;
    logic        o_sync_err;
    logic [15:0] o_err_cnt;
    logic        o_locked;

    dl_recv_if bus();

    dl_recv #(.ERR_LOST_N(LOSTN)) dut (
        .clk_491(clk_491), .rst_491(rst_491), .i_bandwidth_sel(bw_sel),
        .freq(bus.slave), .o_sync_err(o_sync_err), .o_err_cnt(o_err_cnt), .o_locked(o_locked)
    );

    always #1 clk_491 = ~clk_491;

    // model state: word history by cycle, last tfram cycle, period, counters
    int          cyc = 0;
    logic [31:0] hist [8];
    int          m_st, m_tlast, m_p, m_cons;
    logic [15:0] m_err;
    logic [31:0] m_f0, m_f1;
    logic [83:0] pipe1, pipe2, e_check;
    int          n_chk = 0, n_fail = 0;
    int          g_slot = 0, g_p = 8;
    logic [31:0] g_sel = 32'd4;

    function automatic int pdec(input logic [31:0] sel);
        logic [3:0] c;
        c = sel[3:0];
        if (c == 4'd1) return 32;
        if (c == 4'd2 || c == 4'd3) return 16;
        return 8;
    endfunction

    function automatic logic [83:0] obs_v();
        return {bus.o_freq0_fdata, bus.o_freq1_fdata, bus.o_freq_fvalid, bus.o_freq_ffram,
                o_sync_err, o_err_cnt, o_locked};
    endfunction

    // Drive one input cycle; e_check becomes the expectation for the outputs visible now.
    task automatic step(input logic [31:0] d, input logic fr, input logic xa, input logic rs);
        int n, s;
        logic sync, fv, ff, expx;
        @(negedge clk_491);
        rst_491 = rs;
        bus.i_freq_tdata = d;
        bus.i_freq_tfram = fr;
        bus.i_freq_txant = xa;
        bw_sel = g_sel;
        e_check = pipe2;
        pipe2 = pipe1;
        if (rs) begin
            for (int i = 0; i < 8; i++) hist[i] = 32'd0;
            m_st = M_IDLE; m_p = 8; m_cons = 0; m_err = 16'd0;
            m_f0 = 32'd0; m_f1 = 32'd0; m_tlast = cyc;
            pipe1 = '0;
            pipe2 = '0;
        end else begin
            hist[cyc & 7] = d;
            sync = 1'b0; fv = 1'b0; ff = 1'b0;
            n = cyc - m_tlast - 1;
            s = n % 32;
            if (m_st == M_RUN) begin
                expx = ((s % m_p) == m_p - 1);
                if (xa !== expx) begin
                    sync = 1'b1;
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                    m_cons++;
                end else if (xa) begin
                    m_cons = 0;
                end
                if ((s % 8) >= 4) begin
                    fv = 1'b1;
                    m_f0 = hist[(cyc - 4) & 7];
                    m_f1 = d;
                    ff = (n == 4);
                end
            end
            if (m_st == M_RUN && m_cons >= LOSTN) begin
                m_st = M_LOST;
            end else if (m_st != M_RUN && fr) begin
                m_st = M_RUN;
                m_cons = 0;
            end
            if (fr) begin
                m_tlast = cyc;
                m_p = pdec(g_sel);
            end
            pipe1 = {m_f0, m_f1, fv, ff, sync, m_err, (m_st == M_RUN)};
        end
        cyc++;
    endtask

    // Stream generator: txant placed on the cadence the bench itself tracks, optionally dropped.
    task automatic send(input logic fr, input logic drop, input logic [31:0] d);
        step(d, fr, ((g_slot % g_p) == g_p - 1) ^ drop, 1'b0);
        if (fr) begin
            g_slot = 0;
            g_p = pdec(g_sel);
        end else begin
            g_slot = (g_slot + 1) % 32;
        end
    endtask

    task automatic test_reset();
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step($urandom, 1'b1, 1'b1, 1'b1);
        n_chk++;
        if (obs_v() !== 84'd0) begin
            n_fail++; $display("FAIL reset_vals got=%h want=0", obs_v());
        end
        for (int i = 0; i < 12; i++) begin
            step($urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            n_chk++;
            if (obs_v() !== e_check) begin
                n_fail++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
        end
    endtask

    task automatic test_ramp();
        g_sel = 32'd4;
        send(1'b1, 1'b0, $urandom);
        for (int n = 0; n < 40; n++) begin
            send(1'b0, 1'b0, 32'(n));
            n_chk++;
            if (obs_v() !== e_check) begin
                n_fail++; $display("FAIL ramp cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
            if (n == 6) begin
                n_chk++;
                if (bus.o_freq0_fdata !== 32'd0 || bus.o_freq1_fdata !== 32'd4 ||
                    bus.o_freq_fvalid !== 1'b1 || bus.o_freq_ffram !== 1'b1) begin
                    n_fail++; $display("FAIL ramp_first_pair got=%0d,%0d v=%b f=%b want=0,4 v=1 f=1",
                        bus.o_freq0_fdata, bus.o_freq1_fdata, bus.o_freq_fvalid, bus.o_freq_ffram);
                end
            end
            if (n == 14) begin
                n_chk++;
                if (bus.o_freq0_fdata !== 32'd8 || bus.o_freq1_fdata !== 32'd12 || bus.o_freq_ffram !== 1'b0) begin
                    n_fail++; $display("FAIL ramp_second_group got=%0d,%0d f=%b want=8,12 f=0",
                        bus.o_freq0_fdata, bus.o_freq1_fdata, bus.o_freq_ffram);
                end
            end
        end
        n_chk++;
        if (o_err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL ramp_err_cnt got=%0d want=0", o_err_cnt);
        end
    endtask

    task automatic test_bandwidth();
        logic [15:0] base;
        base = o_err_cnt;
        g_sel = 32'd1;
        send(1'b1, 1'b0, $urandom);
        for (int n = 0; n < 100; n++) begin
            if (n == 32) g_sel = 32'hABCD_0002;
            send(n == 64, 1'b0, $urandom);
            n_chk++;
            if (obs_v() !== e_check) begin
                n_fail++; $display("FAIL bandwidth cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
        end
        n_chk++;
        if (o_err_cnt !== base) begin
            n_fail++; $display("FAIL bandwidth_err_cnt got=%0d want=%0d", o_err_cnt, base);
        end
    endtask

    task automatic test_drop();
        logic [15:0] base;
        base = o_err_cnt;
        g_sel = 32'd4;
        send(1'b1, 1'b0, $urandom);
        for (int n = 0; n < 24; n++) begin
            send(1'b0, n == 7, $urandom);
            n_chk++;
            if (obs_v() !== e_check) begin
                n_fail++; $display("FAIL drop cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
            if (n == 9) begin
                n_chk++;
                if (o_sync_err !== 1'b1 || o_err_cnt !== base + 16'd1 || o_locked !== 1'b1) begin
                    n_fail++; $display("FAIL drop_pulse got=%b,%0d,%b want=1,%0d,1",
                        o_sync_err, o_err_cnt, o_locked, base + 16'd1);
                end
            end
        end
    endtask

    task automatic test_lost();
        g_sel = 32'd4;
        send(1'b1, 1'b0, $urandom);
        for (int n = 0; n < 42; n++) begin
            send(1'b0, (n % 8) == 7 && n < 32, $urandom);
            n_chk++;
            if (obs_v() !== e_check) begin
                n_fail++; $display("FAIL lost cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
        end
        n_chk++;
        if (o_locked !== 1'b0 || bus.o_freq_fvalid !== 1'b0) begin
            n_fail++; $display("FAIL lost_state got=%b,%b want=0,0", o_locked, bus.o_freq_fvalid);
        end
        send(1'b1, 1'b0, $urandom);
        for (int n = 0; n < 16; n++) begin
            send(1'b0, 1'b0, $urandom);
            n_chk++;
            if (obs_v() !== e_check) begin
                n_fail++; $display("FAIL relock cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
        end
        n_chk++;
        if (o_locked !== 1'b1) begin
            n_fail++; $display("FAIL relock_state got=%b want=1", o_locked);
        end
    endtask

    task automatic test_saturate();
        g_sel = 32'd4;
        send(1'b1, 1'b0, $urandom);
        for (int n = 0; n < 8; n++) send(1'b0, 1'b0, $urandom);
        force dut.err_cnt_r = 16'hFFFE;
        m_err = 16'hFFFE;
        pipe1[16:1] = 16'hFFFE;
        pipe2[16:1] = 16'hFFFE;
        send(1'b0, 1'b0, $urandom);
        release dut.err_cnt_r;
        for (int n = 0; n < 32; n++) begin
            send(1'b0, g_slot == 7 || g_slot == 15 || g_slot == 23, $urandom);
            n_chk++;
            if (obs_v() !== e_check) begin
                n_fail++; $display("FAIL saturate cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
        end
        n_chk++;
        if (o_err_cnt !== 16'hFFFF || o_locked !== 1'b1) begin
            n_fail++; $display("FAIL saturate_hold got=%h,%b want=ffff,1", o_err_cnt, o_locked);
        end
    endtask

    task automatic test_midreset_realign();
        g_sel = 32'd2;
        send(1'b1, 1'b0, $urandom);
        for (int n = 0; n < 10; n++) send(1'b0, 1'b0, $urandom);
        step($urandom, 1'b0, 1'b0, 1'b1);
        step($urandom, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (obs_v() !== 84'd0) begin
            n_fail++; $display("FAIL midreset_vals got=%h want=0", obs_v());
        end
        for (int n = 0; n < 10; n++) begin
            send(1'b0, 1'b0, $urandom);
            n_chk++;
            if (obs_v() !== e_check || bus.o_freq_fvalid !== 1'b0) begin
                n_fail++; $display("FAIL midreset_idle cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
        end
        g_sel = 32'd4;
        send(1'b1, 1'b0, $urandom);
        for (int n = 0; n < 34; n++) begin
            send(n == 13, 1'b0, $urandom);
            n_chk++;
            if (obs_v() !== e_check) begin
                n_fail++; $display("FAIL realign cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
        end
        n_chk++;
        if (o_err_cnt !== 16'd0 || o_locked !== 1'b1) begin
            n_fail++; $display("FAIL realign_err got=%0d,%b want=0,1", o_err_cnt, o_locked);
        end
    endtask

    task automatic test_random();
        logic fr;
        for (int n = 0; n < 1500; n++) begin
            fr = (g_slot == 31 && $urandom_range(0, 3) != 0) || ($urandom_range(0, 59) == 0);
            if (fr || $urandom_range(0, 15) == 0) g_sel = $urandom;
            send(fr, $urandom_range(0, 24) == 0, $urandom);
            n_chk++;
            if (obs_v() !== e_check) begin
                n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_v(), e_check);
            end
        end
    endtask

    initial begin
        bus.i_freq_tdata = 32'd0;
        bus.i_freq_tfram = 1'b0;
        bus.i_freq_txant = 1'b0;
        pipe1 = '0;
        pipe2 = '0;
        test_reset();
        test_ramp();
        test_bandwidth();
        test_drop();
        test_lost();
        test_saturate();
        test_midreset_realign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
